// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response handshake bundle for seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [2:0]       Signal;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataOut;
    logic             zero;
    logic             overflow;

    modport slave (
        input  in_valid, dataA, dataB, Signal, out_ready,
        output in_ready, out_valid, dataOut, zero, overflow
    );

    modport master (
        output in_valid, dataA, dataB, Signal, out_ready,
        input  in_ready, out_valid, dataOut, zero, overflow
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU with single-cycle ops and a bit-serial unsigned multiply
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_SRL  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic             r_zero;
    logic             r_overflow;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [SHW-1:0]   r_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_sub;
    logic             w_cout;
    logic             w_cin_msb;
    logic             w_ovf;
    logic             w_slt;
    logic             w_res_ovf;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_acc_next;
    logic [SHW-1:0]   w_shamt;

    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // SUB and SLT share the A + ~B + 1 adder path
    assign w_is_sub = bus.Signal[2] & bus.Signal[1];
    assign w_b_op   = w_is_sub ? ~bus.dataB : bus.dataB;
    assign {w_cout, w_sum} = {1'b0, bus.dataA} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
    assign w_cin_msb = w_sum[WIDTH-1] ^ bus.dataA[WIDTH-1] ^ w_b_op[WIDTH-1];
    assign w_ovf     = w_cin_msb ^ w_cout;
    assign w_slt     = w_sum[WIDTH-1] ^ w_ovf;
    assign w_shamt   = bus.dataB[SHW-1:0];
    assign w_res_ovf = (bus.Signal == OP_ADD || bus.Signal == OP_SUB) ? w_ovf : 1'b0;

    always_comb begin
        w_result = '0;
        case (bus.Signal)
            OP_AND:  w_result = bus.dataA & bus.dataB;
            OP_OR:   w_result = bus.dataA | bus.dataB;
            OP_ADD:  w_result = w_sum;
            OP_SUB:  w_result = w_sum;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SRL:  w_result = bus.dataA >> w_shamt;
            OP_SLL:  w_result = bus.dataA << w_shamt;
            default: w_result = '0;
        endcase
    end

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && bus.Signal == OP_MULU) begin
                        // accept implies the output stage is empty or being drained now
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_mcand     <= bus.dataA;
                        r_mplier    <= bus.dataB;
                        r_cnt       <= SHW'(WIDTH - 1);
                        r_state     <= S_MUL;
                    end else if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_data_out  <= w_result;
                        r_zero      <= (w_result == '0);
                        r_overflow  <= w_res_ovf;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == '0) begin
                        r_out_valid <= 1'b1;
                        r_data_out  <= w_acc_next;
                        r_zero      <= (w_acc_next == '0);
                        r_overflow  <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - SHW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dataOut   = r_data_out;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed-vector bench for seq_alu at WIDTH 32 and 8
module tb_seq_alu;
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_SRL  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) if32 ();
    seq_alu_if #(.WIDTH(8))  if8 ();

    seq_alu #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    seq_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if32.in_valid = 1'b1;
        if32.Signal   = op;
        if32.dataA    = a;
        if32.dataB    = b;
        tick();
        if32.in_valid = 1'b0;
    endtask

    task automatic op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if8.in_valid = 1'b1;
        if8.Signal   = op;
        if8.dataA    = a;
        if8.dataB    = b;
        tick();
        if8.in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int busy;
        int seen;
        logic [31:0] held;

        if32.in_valid = 1'b0; if32.out_ready = 1'b1; if32.Signal = 3'b000;
        if32.dataA = '0; if32.dataB = '0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b1; if8.Signal = 3'b000;
        if8.dataA = '0; if8.dataB = '0;

        #2;
        check("rst_out_valid", if32.out_valid, 0);
        check("rst_dataOut",   if32.dataOut, 0);
        check("rst_zero",      if32.zero, 0);
        check("rst_overflow",  if32.overflow, 0);
        tick();
        tick();
        rst_n = 1'b1;
        check("post_rst_in_ready", if32.in_ready, 1);

        op32(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        check("add_valid", if32.out_valid, 1);
        check("add_data",  if32.dataOut, 64'h8000_0000);
        check("add_ovf",   if32.overflow, 1);
        check("add_zero",  if32.zero, 0);

        op32(OP_SUB, 32'd5, 32'd5);
        check("sub_data", if32.dataOut, 0);
        check("sub_zero", if32.zero, 1);
        check("sub_ovf",  if32.overflow, 0);

        op32(OP_SUB, 32'h8000_0000, 32'h1);
        check("sub_ovf_data", if32.dataOut, 64'h7FFF_FFFF);
        check("sub_ovf_flag", if32.overflow, 1);

        op32(OP_SLT, 32'h8000_0000, 32'h1);
        check("slt_neg", if32.dataOut, 1);
        check("slt_ovf0", if32.overflow, 0);

        op32(OP_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        check("slt_ovfcase", if32.dataOut, 0);

        op32(OP_OR, 32'hF000_000F, 32'h0F00_00F0);
        check("or_data", if32.dataOut, 64'hFF00_00FF);

        // back-to-back shifts: one result per cycle
        if32.in_valid = 1'b1; if32.Signal = OP_SLL;
        if32.dataA = 32'h1; if32.dataB = 32'h25;
        tick();
        check("sll_valid", if32.out_valid, 1);
        check("sll_data",  if32.dataOut, 64'h20);
        check("sll_ready", if32.in_ready, 1);
        if32.Signal = OP_SRL; if32.dataA = 32'h8000_0000; if32.dataB = 32'd31;
        tick();
        if32.in_valid = 1'b0;
        check("srl_valid", if32.out_valid, 1);
        check("srl_data",  if32.dataOut, 1);
        tick();
        check("drain_valid", if32.out_valid, 0);

        // back-pressure, with an ignored request pending
        if32.out_ready = 1'b0;
        op32(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("and_data", if32.dataOut, 64'h00F0_1200);
        held = if32.dataOut;
        if32.in_valid = 1'b1; if32.Signal = OP_OR;
        if32.dataA = 32'h1; if32.dataB = 32'h2;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", if32.in_ready, 0);
            tick();
            check("bp_valid", if32.out_valid, 1);
            check("bp_data",  if32.dataOut, 64'h00F0_1200);
        end
        check("bp_held", held, 64'h00F0_1200);
        if32.out_ready = 1'b1;
        #1;
        check("bp_release_ready", if32.in_ready, 1);
        tick();
        if32.in_valid = 1'b0;
        check("bp_or_valid", if32.out_valid, 1);
        check("bp_or_data",  if32.dataOut, 64'h3);
        tick();
        check("bp_drain", if32.out_valid, 0);

        // WIDTH=8 multiply latency and result
        op8(OP_MULU, 8'h0F, 8'h11);
        cyc = 1; busy = 0;
        while (!if8.out_valid && cyc < 40) begin
            if (!if8.in_ready) busy++;
            tick();
            cyc++;
        end
        check("mul8_cycle", cyc, 9);
        check("mul8_busy",  busy, 8);
        check("mul8_data",  if8.dataOut, 64'hFF);
        check("mul8_zero",  if8.zero, 0);
        tick();
        op8(OP_MULU, 8'h10, 8'h10);
        cyc = 1;
        while (!if8.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("mul8b_cycle", cyc, 9);
        check("mul8b_data",  if8.dataOut, 0);
        check("mul8b_zero",  if8.zero, 1);

        // WIDTH=32 multiply with operands changed after accept
        op32(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        if32.dataA = 32'h0; if32.dataB = 32'h0; if32.Signal = OP_ADD;
        cyc = 1;
        while (!if32.out_valid && cyc < 80) begin
            tick();
            cyc++;
        end
        check("mul32_cycle", cyc, 33);
        check("mul32_data",  if32.dataOut, 1);
        check("mul32_ovf",   if32.overflow, 0);
        tick();

        // reset during cycle 4 of a multiply
        op32(OP_MULU, 32'd3, 32'd5);
        tick(); tick(); tick();
        check("mid_mul_busy", if32.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("rstmul_valid", if32.out_valid, 0);
        check("rstmul_data",  if32.dataOut, 0);
        check("rstmul_ready", if32.in_ready, 1);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (if32.out_valid) seen++;
            tick();
        end
        check("rstmul_no_result", seen, 0);
        check("rstmul_ready_after", if32.in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; legal values are 8, 16, 32 and 64.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 in_valid  in  1  operation request valid.
REQ-005 in_ready  out  1  block can accept a request this cycle.
REQ-006 dataA  in  WIDTH  operand A.
REQ-007 dataB  in  WIDTH  operand B; for shifts, only bits [log2(WIDTH)-1:0] give the shift amount.
REQ-008 Signal  in  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MULU, 100 SRL, 101 SLL.
REQ-009 out_valid  out  1  result registers hold an unconsumed result.
REQ-010 out_ready  in  1  consumer takes the result this cycle.
REQ-011 dataOut  out  WIDTH  registered result.
REQ-012 zero  out  1  registered flag: dataOut == 0.
REQ-013 overflow  out  1  registered flag: signed overflow for ADD/SUB; 0 for all other ops.

Function
REQ-014 The block SHALL accept a request when in_valid && in_ready; operands and opcode are captured on that edge.
REQ-015 in_ready SHALL be 1 only when state == IDLE && (!out_valid || out_ready).
REQ-016 States SHALL be IDLE and MUL only; reset enters IDLE.
REQ-017 Single-cycle ops (AND, OR, ADD, SUB, SLT, SRL, SLL) SHALL stay in IDLE. Their result, zero and overflow load on the accept edge, so out_valid = 1 the following cycle (latency 1).
REQ-018 Back-to-back single-cycle ops SHALL sustain one result per cycle while out_ready = 1.
REQ-019 ADD SHALL give A+B mod 2^WIDTH; SUB SHALL give A-B mod 2^WIDTH, computed as A + ~B + 1.
REQ-020 overflow for ADD/SUB SHALL be carry-into-MSB XOR carry-out-of-MSB.
REQ-021 SLT SHALL return 1 when A < B as signed two's complement, else 0, zero-extended. It uses sign(A-B) XOR overflow, so it is correct on overflow.
REQ-022 SRL SHALL be a logical right shift and SLL a logical left shift, zero-filled, by dataB[log2(WIDTH)-1:0].
REQ-023 MULU SHALL move IDLE->MUL on accept and run an unsigned shift-add for exactly WIDTH cycles, one multiplier bit per cycle.
REQ-024 MULU SHALL produce the low WIDTH bits of A*B.
REQ-025 On the last MUL cycle, MULU SHALL load the output registers and return to IDLE; out_valid rises WIDTH+1 cycles after the accept edge.
REQ-026 in_ready SHALL be 0 throughout MUL.
REQ-027 When out_valid && !out_ready, dataOut, zero, overflow and out_valid SHALL hold unchanged (back-pressure).
REQ-028 When out_valid && out_ready with no new load, out_valid SHALL drop to 0 next cycle.
REQ-029 When out_valid && out_ready with a simultaneous accept of a single-cycle op, out_valid SHALL stay 1 and the new result SHALL replace the old.
REQ-030 The output registers are always drained when MUL starts (REQ-015). MUL completion SHALL therefore overwrite them unconditionally.
REQ-031 in_valid while in_ready = 0 SHALL be ignored; the requester holds its request.
REQ-032 Operand and opcode changes after acceptance SHALL NOT affect an in-flight MULU.

Reset
REQ-033 On rst_n = 0, the block SHALL immediately set state = IDLE, out_valid = 0, dataOut = 0, zero = 0, overflow = 0, and clear the multiply accumulator, multiplicand, multiplier and cycle counter.
REQ-034 Reset asserted mid-MULU SHALL abandon the operation; no result is produced after release.
REQ-035 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-036 WIDTH=32: ADD A=0x7FFFFFFF, B=1, out_ready=1 -> next cycle dataOut=0x80000000, overflow=1, zero=0.
REQ-037 WIDTH=32: SUB A=5, B=5 -> dataOut=0, zero=1, overflow=0. SLT A=0x80000000, B=1 -> dataOut=1.
REQ-038 WIDTH=8: MULU A=0x0F, B=0x11 -> in_ready=0 for 8 cycles, out_valid at accept+9, dataOut=0xFF. MULU A=0x10, B=0x10 -> dataOut=0x00, zero=1.
REQ-039 WIDTH=32: SLL A=1, B=0x25 -> dataOut=0x20; SRL A=0x80000000, B=31 -> dataOut=1. Both issued back-to-back with out_ready=1 -> two consecutive out_valid cycles.
REQ-040 Back-pressure: hold out_ready=0 for 3 cycles after an AND result -> dataOut stable, in_ready=0. Raise out_ready with in_valid=1 (OR) -> in_ready=1 and the OR result replaces the AND result next cycle.
REQ-041 Assert rst_n=0 during cycle 4 of a WIDTH=32 MULU -> outputs clear immediately; after release out_valid stays 0 and in_ready=1.
